// File: rtl/lstm_acc_pkg.sv
// Shared definitions for the accelerator's serial/parallel boundary blocks.
// The element width and vector length defaults are shared with the input
// deserializer, so both ends of the datapath agree on the serial format.
package lstm_acc_pkg;

  localparam int ELEMENT_BITS_DEF = 8;
  localparam int FEATURES_DEF     = 4;
  localparam int FEATURE_BITS_DEF = 4;

  // Number of vectors held in the ping-pong buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/lstm_serializer_if.sv
// Bus between a parallel vector producer and a serial element consumer.
// The master drives the load side and accepts the serial stream. The slave
// (the serializer) does the reverse.
interface lstm_serializer_if
  import lstm_acc_pkg::*;
#(
  parameter int ELEMENT_BITS = ELEMENT_BITS_DEF,
  parameter int FEATURES     = FEATURES_DEF
);

  logic                             load_valid;
  logic                             load_ready;
  logic [ELEMENT_BITS*FEATURES-1:0] parallel_data_in;
  logic                             serial_valid;
  logic                             serial_ready;
  logic [ELEMENT_BITS-1:0]          serial_data_out;
  logic                             last;
  logic                             done;

  modport master (
    output load_valid, parallel_data_in, serial_ready,
    input  load_ready, serial_valid, serial_data_out, last, done
  );

  modport slave (
    input  load_valid, parallel_data_in, serial_ready,
    output load_ready, serial_valid, serial_data_out, last, done
  );

endinterface

// File: rtl/lstm_serializer.sv
// Output-side serializer. It stores up to two result vectors in a ping-pong
// buffer and streams them out one element per cycle, element 0 first.
// Every output is derived only from registered state. load_ready in
// particular never looks at serial_ready, which keeps the upstream timing
// path short. The cost is that a load arriving in the same cycle as a
// last beat while FULL waits one cycle.
module lstm_serializer
  import lstm_acc_pkg::*;
#(
  parameter int ELEMENT_BITS = ELEMENT_BITS_DEF,
  parameter int FEATURES     = FEATURES_DEF,
  parameter int FEATURE_BITS = FEATURE_BITS_DEF
) (
  input logic              clk,
  input logic              reset_n,
  lstm_serializer_if.slave bus
);

  localparam int VEC_BITS = ELEMENT_BITS * FEATURES;
  localparam logic [FEATURE_BITS-1:0] IDX_LAST = FEATURE_BITS'(FEATURES - 1);

  logic [1:0][VEC_BITS-1:0] slot_q, slot_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  occ_e                     occ_q, occ_d;
  logic [FEATURE_BITS-1:0]  idx_q, idx_d;
  logic                     done_q, done_d;

  logic load_fire;
  logic beat_fire;
  logic last_beat;

  // Handshake outputs and the element mux. All of these come from state only.
  always_comb begin
    bus.load_ready      = (occ_q != FULL);
    bus.serial_valid    = (occ_q != EMPTY);
    bus.serial_data_out = slot_q[rd_ptr_q][idx_q*ELEMENT_BITS +: ELEMENT_BITS];
    bus.last            = bus.serial_valid && (idx_q == IDX_LAST);
    bus.done            = done_q;
  end

  assign load_fire = bus.load_valid && bus.load_ready;
  assign beat_fire = bus.serial_valid && bus.serial_ready;
  assign last_beat = beat_fire && bus.last;

  // Next-state logic for the buffer, the pointers, occupancy and the element index.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    // A slot is written only when free, so a draining slot is never overwritten.
    if (load_fire) begin
      slot_d[wr_ptr_q] = bus.parallel_data_in;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (beat_fire) begin
      if (last_beat) begin
        idx_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
        done_d   = 1'b1;
      end else begin
        idx_d = idx_q + FEATURE_BITS'(1);
      end
    end

    // A simultaneous load and last beat leave the occupancy unchanged.
    unique case ({load_fire, last_beat})
      2'b10:   occ_d = (occ_q == EMPTY) ? HALF : FULL;
      2'b01:   occ_d = (occ_q == FULL)  ? HALF : EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // State registers. Reset discards both buffered vectors at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= EMPTY;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_lstm_serializer.sv
// Bench for lstm_serializer. The reference model is a queue of whole
// vectors plus a position within the head vector. Each cycle it predicts
// the handshake outputs, the current element, last and done. It then
// applies the transfers that happen at the following edge.
module tb_lstm_serializer;

  localparam int EB = 8;
  localparam int NF = 4;
  localparam int FB = 4;
  localparam int W  = EB * NF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  lstm_serializer_if #(.ELEMENT_BITS(EB), .FEATURES(NF)) bus ();

  lstm_serializer #(.ELEMENT_BITS(EB), .FEATURES(NF), .FEATURE_BITS(FB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [W-1:0] mq[$];
  int           pos = 0;
  bit           done_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pos    = 0;
    done_m = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".load_ready"},   32'(bus.load_ready),      32'd1);
    chk({tag, ".serial_valid"}, 32'(bus.serial_valid),    32'd0);
    chk({tag, ".data"},         32'(bus.serial_data_out), 32'd0);
    chk({tag, ".last"},         32'(bus.last),            32'd0);
    chk({tag, ".done"},         32'(bus.done),            32'd0);
  endtask

  // One clock cycle: drive the inputs, compare the outputs with the model,
  // then advance the model across the rising edge.
  task automatic step(input bit lv, input logic [W-1:0] d, input bit sr,
                      input string tag, output bit acc);
    bit           ready_m, valid_m, last_m;
    logic [EB-1:0] data_m;
    @(negedge clk);
    bus.load_valid       = lv;
    bus.parallel_data_in = d;
    bus.serial_ready     = sr;
    ready_m = (mq.size() < 2);
    valid_m = (mq.size() > 0);
    data_m  = valid_m ? mq[0][pos*EB +: EB] : '0;
    last_m  = valid_m && (pos == NF - 1);
    chk({tag, ".load_ready"},   32'(bus.load_ready),   32'(ready_m));
    chk({tag, ".serial_valid"}, 32'(bus.serial_valid), 32'(valid_m));
    chk({tag, ".last"},         32'(bus.last),         32'(last_m));
    chk({tag, ".done"},         32'(bus.done),         32'(done_m));
    if (valid_m) chk({tag, ".data"}, 32'(bus.serial_data_out), 32'(data_m));
    @(posedge clk);
    done_m = 1'b0;
    if (valid_m && sr) begin
      if (pos == NF - 1) begin
        void'(mq.pop_front());
        pos    = 0;
        done_m = 1'b1;
      end else begin
        pos++;
      end
    end
    acc = lv && ready_m;
    if (acc) mq.push_back(d);
  endtask

  initial begin
    bit acc;
    bit pv;
    logic [W-1:0] pd;
    int n;

    bus.load_valid       = 1'b0;
    bus.parallel_data_in = '0;
    bus.serial_ready     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single vector: 11,22,33,44, then done
    step(1'b1, 32'h44332211, 1'b1, "single", acc);
    repeat (6) step(1'b0, 32'h0, 1'b1, "single", acc);

    // Backpressure with serial_ready 1,0,0,1,...
    step(1'b1, 32'hA4A3A2A1, 1'b1, "bp", acc);
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0, (i % 3) == 0, "bp", acc);

    // Back-to-back vectors stream with no gap
    step(1'b1, 32'h44332211, 1'b1, "b2b", acc);
    step(1'b1, 32'h88776655, 1'b1, "b2b", acc);
    repeat (9) step(1'b0, 32'h0, 1'b1, "b2b", acc);

    // Full buffer: three loads while stalled; the third waits for a free slot
    step(1'b1, 32'h13121110, 1'b0, "full", acc);
    step(1'b1, 32'h23222120, 1'b0, "full", acc);
    step(1'b1, 32'h33323130, 1'b0, "full", acc);
    chk("full.third_blocked", 32'(acc), 32'd0);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(1'b1, 32'h33323130, 1'b1, "full", acc);
      n++;
    end
    chk("full.third_accepted", 32'(acc), 32'd1);
    chk("full.wait_cycles", 32'(n), 32'(NF + 1));
    repeat (12) step(1'b0, 32'h0, 1'b1, "full", acc);

    // Reset mid-stream after the second beat
    step(1'b1, 32'hDDCCBBAA, 1'b1, "rst", acc);
    step(1'b1, 32'h5F5E5D5C, 1'b1, "rst", acc);
    step(1'b0, 32'h0, 1'b1, "rst", acc);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst.async");
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 32'h0D0C0B0A, 1'b1, "rst.fresh", acc);
    repeat (6) step(1'b0, 32'h0, 1'b1, "rst.fresh", acc);

    // Random loads and backpressure; upstream holds an unaccepted load
    pv = 1'b0;
    pd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pv && ($urandom_range(0, 2) != 0)) begin
        pv = 1'b1;
        pd = $urandom;
      end
      step(pv, pd, $urandom_range(0, 3) != 0, "rand", acc);
      if (acc) pv = 1'b0;
    end
    repeat (12) step(1'b0, 32'h0, 1'b1, "drain", acc);
    chk("drain.empty", 32'(bus.serial_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lstm_serializer.md
# lstm_serializer

Output-side serializer for the accelerator datapath. It accepts a full result vector of FEATURES elements in one parallel word and streams it out one element per cycle under a valid/ready handshake. Its serial output format matches the format the input deserializer consumes. It holds two vectors in a ping-pong buffer, so a new vector can load while the previous one drains, with no bubbles between vectors.

## Interface
Parameters:
- ELEMENT_BITS, 8, width of one element
- FEATURES, 4, elements per vector
- FEATURE_BITS, 4, width of the element index counter; FEATURES <= 2**FEATURE_BITS required

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  parallel_data_in holds a vector to load
- load_ready  out  1  a buffer slot is free; a load is accepted when load_valid && load_ready at a clock edge
- parallel_data_in  in  ELEMENT_BITS*FEATURES  vector; element k occupies bits [k*ELEMENT_BITS +: ELEMENT_BITS]
- serial_valid  out  1  serial_data_out holds a valid element
- serial_ready  in  1  downstream accepts; a beat transfers when serial_valid && serial_ready
- serial_data_out  out  ELEMENT_BITS  current element
- last  out  1  current element is element FEATURES-1 of its vector
- done  out  1  one-cycle pulse after the last beat of each vector

## Operation
- Storage: two slots of ELEMENT_BITS*FEATURES, plus a write pointer wr_ptr (1 bit), a read pointer rd_ptr (1 bit), an occupancy count occ (0..2), and an element index idx (FEATURE_BITS).
- Occupancy states are EMPTY (occ=0), HALF (occ=1) and FULL (occ=2).
- load_ready = (occ != 2). It depends only on registered state and never combinationally on serial_ready.
- serial_valid = (occ != 0).
- serial_data_out = slot[rd_ptr][idx*ELEMENT_BITS +: ELEMENT_BITS].
- last = serial_valid && (idx == FEATURES-1).
- Load accepted: slot[wr_ptr] is written with parallel_data_in, and wr_ptr toggles.
- Beat transferred, not last: idx increments.
- Beat transferred, last: idx returns to 0, rd_ptr toggles, and done pulses on the next cycle.
- Occupancy update:
  - +1 on a load accepted without a last beat
  - −1 on a last beat without a load
  - unchanged when both happen in the same cycle
- When serial_valid=0, idx stays at 0.
- Elements are emitted in ascending index order: element 0 first.
- While serial_valid=1 and serial_ready=0, serial_data_out, last and idx hold stable.
- Slot contents are not modified after load until that slot has been fully drained.
- No overflow is possible: a load while FULL is not accepted, and upstream holds load_valid.
- Widths: the idx compare and increment are done at FEATURE_BITS. idx never exceeds FEATURES-1.

## Timing
- Reset values:
  - load_ready=1
  - serial_valid=0
  - serial_data_out=0
  - last=0
  - done=0
  - occ=0, wr_ptr=0, rd_ptr=0, idx=0, slots=0
- Reset takes effect asynchronously mid-stream and discards both buffered vectors.
- Latency: a load accepted at edge N gives serial_valid=1 and element 0 in the cycle after edge N.
- Throughput: with serial_ready held at 1, a vector drains in exactly FEATURES cycles. Back-to-back vectors stream with no idle cycle.
- done is high for exactly one cycle, starting at the edge that transfers the last beat.
- Simultaneous load and last beat while FULL: the load is not accepted because load_ready=0 that cycle. load_ready rises after the edge, and the load is accepted on the next edge.
- Simultaneous load and last beat while HALF: both take effect, and occ stays 1.

## Structure
- Shared package lstm_acc_pkg holds:
  - the default ELEMENT_BITS and FEATURES constants, shared with the input deserializer
  - an occupancy enum typedef (EMPTY, HALF, FULL)
- No sub-module is needed; the block is a single module.

## Test plan
- Single vector:
  - Stimulus: load 0x44332211 (ELEMENT_BITS=8, FEATURES=4), serial_ready=1.
  - Response: serial_data_out is 11, 22, 33, 44 on consecutive cycles starting one cycle after the load; last=1 only on 44; done pulses one cycle after the 44 beat.
- Backpressure:
  - Stimulus: serial_ready toggles 1, 0, 0, 1, …
  - Response: each element is held stable while ready=0; exactly four beats in order; no duplicates or drops.
- Back-to-back vectors:
  - Stimulus: load 0x44332211, then 0x88776655 on the next cycle, serial_ready=1.
  - Response: eight consecutive beats 11…88 with no gap; two done pulses.
- Full buffer:
  - Stimulus: three loads with serial_ready=0.
  - Response: load_ready=0 after the second load; the third vector is accepted one cycle after the first vector's last beat; all twelve elements arrive in order.
- Reset mid-stream:
  - Stimulus: assert reset_n=0 after the second beat.
  - Response: all outputs go to their reset values immediately; after release, a fresh load streams from element 0.
